// File: rtl/execute_stage_if.sv
// Execute stage bundle: upstream valid/ready operand handshake plus the register-file write port.
// Parameters must match those of the execute_stage instance it is connected to.
interface execute_stage_if #(
    parameter int NUM_REGS_LOG = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int OP_WIDTH     = 4
);
    logic                    valid_i;
    logic                    ready_o;
    logic [OP_WIDTH-1:0]     op_i;
    logic [DATA_WIDTH-1:0]   rd0_i;
    logic [DATA_WIDTH-1:0]   rd1_i;
    logic [NUM_REGS_LOG-1:0] dest_i;
    logic                    wen_o;
    logic [NUM_REGS_LOG-1:0] wa_o;
    logic [DATA_WIDTH-1:0]   wd_o;

    modport slave (
        input  valid_i, op_i, rd0_i, rd1_i, dest_i,
        output ready_o, wen_o, wa_o, wd_o
    );

    modport master (
        output valid_i, op_i, rd0_i, rd1_i, dest_i,
        input  ready_o, wen_o, wa_o, wd_o
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU feeding the register-file write port, with an optional
// iterative shift-add multiply enabled by defining EXECUTE_STAGE_MUL_EN.
module execute_stage #(
    parameter int NUM_REGS_LOG = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int OP_WIDTH     = 4
) (
    input logic             clk,
    input logic             reset,
    execute_stage_if.slave  bus
);
    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_PASSB = OP_WIDTH'(9);
`ifdef EXECUTE_STAGE_MUL_EN
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(10);
`endif

    logic                    r_wen;
    logic [NUM_REGS_LOG-1:0] r_wa;
    logic [DATA_WIDTH-1:0]   r_wd;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_wr;
    logic [DATA_WIDTH-1:0]   w_res;
    logic [SHW-1:0]          w_shamt;

`ifdef EXECUTE_STAGE_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_ma;
    logic [DATA_WIDTH-1:0]   r_mb;
    logic [DATA_WIDTH-1:0]   r_prod;
    logic [SHW-1:0]          r_cnt;
    logic [NUM_REGS_LOG-1:0] r_mdest;
    logic [DATA_WIDTH-1:0]   w_prod_next;

    assign w_ready     = ~reset & (r_state == S_IDLE);
    assign w_prod_next = r_mb[0] ? (r_prod + r_ma) : r_prod;
`else
    assign w_ready = ~reset;
`endif

    assign w_accept     = bus.valid_i & w_ready;
    assign w_shamt      = bus.rd1_i[SHW-1:0];
    assign bus.ready_o  = w_ready;
    assign bus.wen_o    = r_wen;
    assign bus.wa_o     = r_wa;
    assign bus.wd_o     = r_wd;

    // Unsupported opcodes (including MUL, which the FSM handles) report w_wr=0.
    always_comb begin
        w_wr  = 1'b1;
        w_res = '0;
        case (bus.op_i)
            OP_ADD:   w_res = bus.rd0_i + bus.rd1_i;
            OP_SUB:   w_res = bus.rd0_i - bus.rd1_i;
            OP_AND:   w_res = bus.rd0_i & bus.rd1_i;
            OP_OR:    w_res = bus.rd0_i | bus.rd1_i;
            OP_XOR:   w_res = bus.rd0_i ^ bus.rd1_i;
            OP_SLT:   w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.rd0_i) < $signed(bus.rd1_i))};
            OP_SLL:   w_res = bus.rd0_i << w_shamt;
            OP_SRL:   w_res = bus.rd0_i >> w_shamt;
            OP_SRA:   w_res = DATA_WIDTH'($signed(bus.rd0_i) >>> w_shamt);
            OP_PASSB: w_res = bus.rd1_i;
            default:  w_wr  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_wa    <= '0;
            r_wd    <= '0;
`ifdef EXECUTE_STAGE_MUL_EN
            r_state <= S_IDLE;
            r_ma    <= '0;
            r_mb    <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_mdest <= '0;
`endif
        end else begin
            r_wen <= 1'b0;
`ifdef EXECUTE_STAGE_MUL_EN
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.op_i == OP_MUL) begin
                            r_state <= S_MUL;
                            r_ma    <= bus.rd0_i;
                            r_mb    <= bus.rd1_i;
                            r_mdest <= bus.dest_i;
                            r_cnt   <= SHW'(DATA_WIDTH - 1);
                            r_prod  <= '0;
                        end else if (w_wr) begin
                            r_wen <= 1'b1;
                            r_wa  <= bus.dest_i;
                            r_wd  <= w_res;
                        end
                    end
                end
                S_MUL: begin
                    // Fixed DATA_WIDTH steps; the last one writes straight to the port.
                    r_prod <= w_prod_next;
                    r_ma   <= r_ma << 1;
                    r_mb   <= r_mb >> 1;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_wen   <= 1'b1;
                        r_wa    <= r_mdest;
                        r_wd    <= w_prod_next;
                    end
                end
            endcase
`else
            if (w_accept && w_wr) begin
                r_wen <= 1'b1;
                r_wa  <= bus.dest_i;
                r_wd  <= w_res;
            end
`endif
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, multi-cycle corner sequences,
// and randomized ops against a behavioural model.
module tb_execute_stage;
    localparam int NRL = 3;
    localparam int DW  = 16;
    localparam int OPW = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    execute_stage_if #(.NUM_REGS_LOG(NRL), .DATA_WIDTH(DW), .OP_WIDTH(OPW)) bus ();

    execute_stage #(.NUM_REGS_LOG(NRL), .DATA_WIDTH(DW), .OP_WIDTH(OPW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dest;
        logic        wen;
        logic [2:0]  wa;
        logic [15:0] wd;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] d);
        bus.valid_i = v;
        bus.op_i    = op;
        bus.rd0_i   = a;
        bus.rd1_i   = b;
        bus.dest_i  = d;
    endtask

    function automatic int s16(input logic [15:0] x);
        return x[15] ? int'(x) - 65536 : int'(x);
    endfunction

    // Behavioural reference: what each opcode should write, straight from the opcode rules.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output bit wr, output logic [15:0] res, output bit is_mul);
        int amt;
        amt    = int'(b) % 16;
        wr     = 1'b1;
        is_mul = 1'b0;
        res    = 16'h0;
        case (int'(op))
            0:  res = 16'((int'(a) + int'(b)) % 65536);
            1:  res = 16'((int'(a) - int'(b) + 65536) % 65536);
            2:  res = a & b;
            3:  res = a | b;
            4:  res = a ^ b;
            5:  res = (s16(a) < s16(b)) ? 16'd1 : 16'd0;
            6:  res = 16'((int'(a) * (2 ** amt)) % 65536);
            7:  res = 16'(int'(a) / (2 ** amt));
            8:  res = 16'((s16(a) >>> amt) & 32'hFFFF);
            9:  res = b;
`ifdef EXECUTE_STAGE_MUL_EN
            10: begin
                res    = 16'((longint'(a) * longint'(b)) % 65536);
                is_mul = 1'b1;
            end
`endif
            default: wr = 1'b0;
        endcase
    endfunction

    logic [2:0]  exp_wa;
    logic [15:0] exp_wd;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);

        vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 3'd3, 1'b1, 3'd3, 16'h8000};
        vecs[1]  = '{4'd1,  16'h0000, 16'h0001, 3'd4, 1'b1, 3'd4, 16'hFFFF};
        vecs[2]  = '{4'd5,  16'hFFFF, 16'h0001, 3'd1, 1'b1, 3'd1, 16'h0001};
        vecs[3]  = '{4'd8,  16'h8000, 16'h0013, 3'd6, 1'b1, 3'd6, 16'hF000};
        vecs[4]  = '{4'd7,  16'h8000, 16'h0013, 3'd7, 1'b1, 3'd7, 16'h1000};
        vecs[5]  = '{4'd15, 16'h1234, 16'h5678, 3'd2, 1'b0, 3'd7, 16'h1000};
        vecs[6]  = '{4'd6,  16'h0003, 16'h0021, 3'd0, 1'b1, 3'd0, 16'h0006};
        vecs[7]  = '{4'd2,  16'hF0F0, 16'hFF00, 3'd5, 1'b1, 3'd5, 16'hF000};
        vecs[8]  = '{4'd3,  16'hF0F0, 16'h0F00, 3'd2, 1'b1, 3'd2, 16'hFFF0};
        vecs[9]  = '{4'd4,  16'hFFFF, 16'h00FF, 3'd3, 1'b1, 3'd3, 16'hFF00};
        vecs[10] = '{4'd9,  16'h1234, 16'hABCD, 3'd4, 1'b1, 3'd4, 16'hABCD};
        vecs[11] = '{4'd5,  16'h0001, 16'hFFFF, 3'd1, 1'b1, 3'd1, 16'h0000};
        vecs[12] = '{4'd0,  16'hFFFF, 16'h0001, 3'd7, 1'b1, 3'd7, 16'h0000};
        vecs[13] = '{4'd11, 16'hAAAA, 16'h5555, 3'd6, 1'b0, 3'd7, 16'h0000};

        // Reset behaviour
        tick();
        chk("rst_ready_c1", 32'(bus.ready_o), 32'd0);
        tick();
        chk("rst_ready_c2", 32'(bus.ready_o), 32'd0);
        chk("rst_wen", 32'(bus.wen_o), 32'd0);
        chk("rst_wa", 32'(bus.wa_o), 32'd0);
        chk("rst_wd", 32'(bus.wd_o), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.ready_o), 32'd1);

        // Back-to-back table stream
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest);
            tick();
            chk($sformatf("vec%0d_wen", i), 32'(bus.wen_o), 32'(vecs[i].wen));
            chk($sformatf("vec%0d_wa", i), 32'(bus.wa_o), 32'(vecs[i].wa));
            chk($sformatf("vec%0d_wd", i), 32'(bus.wd_o), 32'(vecs[i].wd));
            chk($sformatf("vec%0d_ready", i), 32'(bus.ready_o), 32'd1);
        end
        exp_wa = 3'd7;
        exp_wd = 16'h0000;

`ifdef EXECUTE_STAGE_MUL_EN
        drive(1'b1, 4'd10, 16'h0123, 16'h0010, 3'd5);
        tick();
        drive(1'b1, 4'd0, 16'h0001, 16'h0001, 3'd7);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("mul1_ready_c%0d", k), 32'(bus.ready_o), 32'd0);
            chk($sformatf("mul1_wen_c%0d", k), 32'(bus.wen_o), 32'd0);
            tick();
        end
        chk("mul1_wen", 32'(bus.wen_o), 32'd1);
        chk("mul1_wa", 32'(bus.wa_o), 32'd5);
        chk("mul1_wd", 32'(bus.wd_o), 32'h1230);
        chk("mul1_ready_done", 32'(bus.ready_o), 32'd1);

        drive(1'b1, 4'd10, 16'h0100, 16'h0100, 3'd6);
        tick();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("mul2_wen_c%0d", k), 32'(bus.wen_o), 32'd0);
            tick();
        end
        chk("mul2_wen", 32'(bus.wen_o), 32'd1);
        chk("mul2_wa", 32'(bus.wa_o), 32'd6);
        chk("mul2_wd", 32'(bus.wd_o), 32'h0000);

        drive(1'b1, 4'd10, 16'h0005, 16'h0003, 3'd1);
        tick();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mulrst_ready", 32'(bus.ready_o), 32'd1);
        chk("mulrst_wa", 32'(bus.wa_o), 32'd0);
        chk("mulrst_wd", 32'(bus.wd_o), 32'd0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("mulrst_nowen_c%0d", k), 32'(bus.wen_o), 32'd0);
            tick();
        end
        exp_wa = 3'd0;
        exp_wd = 16'h0000;
`else
        drive(1'b1, 4'd10, 16'h0123, 16'h0010, 3'd2);
        tick();
        chk("op10_wen", 32'(bus.wen_o), 32'd0);
        chk("op10_wa", 32'(bus.wa_o), 32'(exp_wa));
        chk("op10_wd", 32'(bus.wd_o), 32'(exp_wd));
        chk("op10_ready", 32'(bus.ready_o), 32'd1);
`endif

        // Randomized ops against the model
        for (int it = 0; it < 300; it++) begin
            logic        v;
            logic [3:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            logic [2:0]  d;
            logic [15:0] res;
            bit          wr;
            bit          is_mul;
            int          cyc;
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            d  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 16'h8000;
                1: b = 16'hFFFF;
                2: a = 16'h7FFF;
                default: ;
            endcase
            if (op == 4'd10 && $urandom_range(0, 3) != 0) op = 4'd0;
            drive(v, op, a, b, d);
            model(op, a, b, wr, res, is_mul);
            tick();
            if (v && is_mul) begin
                bus.valid_i = 1'b0;
                cyc = 1;
                while (bus.wen_o !== 1'b1 && cyc < 40) begin
                    chk("rand_mul_busy_ready", 32'(bus.ready_o), 32'd0);
                    tick();
                    cyc++;
                end
                chk("rand_mul_latency", 32'(cyc), 32'd17);
                exp_wa = d;
                exp_wd = res;
                chk("rand_wen", 32'(bus.wen_o), 32'd1);
            end else if (v && wr) begin
                exp_wa = d;
                exp_wd = res;
                chk($sformatf("rand%0d_op%0d_wen", it, op), 32'(bus.wen_o), 32'd1);
            end else begin
                chk($sformatf("rand%0d_op%0d_nowen", it, op), 32'(bus.wen_o), 32'd0);
            end
            chk($sformatf("rand%0d_op%0d_wa", it, op), 32'(bus.wa_o), 32'(exp_wa));
            chk($sformatf("rand%0d_op%0d_wd", it, op), 32'(bus.wd_o), 32'(exp_wd));
            chk($sformatf("rand%0d_ready", it), 32'(bus.ready_o), 32'd1);
        end

        drive(1'b0, 4'd0, 16'h0, 16'h0, 3'd0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
